// File: rtl/hci_core_memmap_demux_if.sv
// HCI core bundle: request channel plus an in-order response channel.
// The initiator side uses modport master, the target side uses modport slave.
interface hci_core_intf #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32,
   parameter int unsigned UW = 2
);
   logic            req;
   logic            gnt;
   logic [AW-1:0]   add;
   logic            wen;
   logic [DW-1:0]   data;
   logic [DW/8-1:0] be;
   logic [UW-1:0]   user;
   logic            r_valid;
   logic [DW-1:0]   r_data;
   logic            r_opc;
   logic [UW-1:0]   r_user;

   modport master (
      output req, add, wen, data, be, user,
      input  gnt, r_valid, r_data, r_opc, r_user
   );

   modport slave (
      input  req, add, wen, data, be, user,
      output gnt, r_valid, r_data, r_opc, r_user
   );
endinterface

// File: rtl/hci_core_memmap_demux.sv
// Address-decoding demux from one HCI initiator to NB_TARGET targets using a runtime region table.
// All outstanding requests share one target, so responses come back in order.
module hci_core_memmap_demux #(
   parameter int unsigned NB_REGION       = 4,
   parameter int unsigned NB_TARGET       = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned AW              = 32,
   parameter int unsigned DW              = 32,
   parameter int unsigned UW              = 2,
   parameter logic [31:0] ERR_DATA        = 32'hbadacce5,
   localparam int unsigned TW             = (NB_TARGET > 1) ? $clog2(NB_TARGET) : 1,
   localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic [NB_REGION*AW-1:0] region_start_i,
   input  logic [NB_REGION*AW-1:0] region_end_i,
   input  logic [NB_REGION*TW-1:0] region_target_i,
   hci_core_intf.slave           slave,
   hci_core_intf.master          master [NB_TARGET],
   output logic                  err_o,
   output logic [AW-1:0]         err_addr_o
);

   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

   logic                 dec_err;
   logic [TW-1:0]        dec_idx;
   logic                 same_tgt;
   logic                 issue_ok;
   logic                 gnt;
   logic                 accept;
   logic                 r_valid;
   logic [CW-1:0]        cnt_q;
   logic                 cur_err_q;
   logic [TW-1:0]        cur_idx_q;
   logic                 err_q;
   logic [AW-1:0]        err_addr_q;

   logic [NB_TARGET-1:0] tgt_gnt;
   logic [NB_TARGET-1:0] tgt_rvalid;
   logic [NB_TARGET-1:0] tgt_ropc;
   logic [DW-1:0]        tgt_rdata [NB_TARGET];
   logic [UW-1:0]        tgt_ruser [NB_TARGET];

   // Scanning from the highest region down lets the lowest-index hit overwrite the others.
   always_comb begin
      dec_err = 1'b1;
      dec_idx = '0;
      for (int i = int'(NB_REGION) - 1; i >= 0; i--) begin
         if ((region_start_i[i*AW +: AW] < region_end_i[i*AW +: AW]) &&
             (slave.add >= region_start_i[i*AW +: AW]) &&
             (slave.add <  region_end_i[i*AW +: AW])) begin
            dec_err = 1'b0;
            dec_idx = region_target_i[i*TW +: TW];
         end
      end
      if (!dec_err && (32'(dec_idx) >= NB_TARGET)) begin
         dec_err = 1'b1;
         dec_idx = '0;
      end
   end

   always_comb begin
      same_tgt = (dec_err == cur_err_q) && (dec_err || (dec_idx == cur_idx_q));
      issue_ok = (cnt_q != CNT_MAX) && ((cnt_q == '0) || same_tgt);
      gnt      = issue_ok & (dec_err ? slave.req : tgt_gnt[dec_idx]);
   end

   assign slave.gnt = gnt;
   assign accept    = slave.req & gnt;

   for (genvar k = 0; k < NB_TARGET; k++) begin : gen_master
      assign master[k].req  = slave.req & issue_ok & ~dec_err & (dec_idx == TW'(k));
      assign master[k].add  = slave.add;
      assign master[k].wen  = slave.wen;
      assign master[k].data = slave.data;
      assign master[k].be   = slave.be;
      assign master[k].user = slave.user;

      assign tgt_gnt[k]    = master[k].gnt;
      assign tgt_rvalid[k] = master[k].r_valid;
      assign tgt_rdata[k]  = master[k].r_data;
      assign tgt_ropc[k]   = master[k].r_opc;
      assign tgt_ruser[k]  = master[k].r_user;

      // A target may only respond while it owns the outstanding requests.
      a_rsp_owner : assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
         tgt_rvalid[k] |-> ((cnt_q != '0) && !cur_err_q && (cur_idx_q == TW'(k))));
   end

   // Error responses are generated locally, one per cycle, until the ERR requests drain.
   always_comb begin
      r_valid      = 1'b0;
      slave.r_data = '0;
      slave.r_opc  = 1'b0;
      slave.r_user = '0;
      if (cnt_q != '0) begin
         if (cur_err_q) begin
            r_valid      = 1'b1;
            slave.r_data = DW'(ERR_DATA);
            slave.r_opc  = 1'b1;
         end else begin
            r_valid      = tgt_rvalid[cur_idx_q];
            slave.r_data = tgt_rdata[cur_idx_q];
            slave.r_opc  = tgt_ropc[cur_idx_q];
            slave.r_user = tgt_ruser[cur_idx_q];
         end
      end
   end

   assign slave.r_valid = r_valid;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         cnt_q      <= '0;
         cur_err_q  <= 1'b0;
         cur_idx_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         case ({accept, r_valid})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (accept) begin
            cur_err_q <= dec_err;
            cur_idx_q <= dec_idx;
         end
         if (accept && dec_err && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= slave.add;
         end
      end
   end

   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_hci_core_memmap_demux.sv
// Directed scenarios followed by randomized traffic checked against a queue-based model
// of the outstanding-request ordering and decode rules.
module tb_hci_core_memmap_demux;

   localparam int unsigned NB_REGION = 4;
   localparam int unsigned NB_TARGET = 2;
   localparam int unsigned MAX_OUT   = 4;
   localparam int unsigned AW        = 32;
   localparam int unsigned DW        = 32;
   localparam int unsigned UW        = 2;
   localparam logic [DW-1:0] ERR_WORD = 32'hbadacce5;
   localparam int ERR_TGT = -1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst;
   logic                    clear;
   logic [NB_REGION*AW-1:0] region_start;
   logic [NB_REGION*AW-1:0] region_end;
   logic [NB_REGION-1:0]    region_target;
   logic                    err;
   logic [AW-1:0]           err_addr;

   hci_core_intf #(.AW(AW), .DW(DW), .UW(UW)) slv ();
   hci_core_intf #(.AW(AW), .DW(DW), .UW(UW)) mst [NB_TARGET] ();

   logic [NB_TARGET-1:0] tgt_gnt;
   logic [NB_TARGET-1:0] tgt_rvalid;
   logic [NB_TARGET-1:0] tgt_ropc;
   logic [DW-1:0]        tgt_rdata [NB_TARGET];
   logic [UW-1:0]        tgt_ruser [NB_TARGET];
   logic [NB_TARGET-1:0] mreq;
   logic [AW-1:0]        madd [NB_TARGET];

   for (genvar g = 0; g < NB_TARGET; g++) begin : gen_tgt
      assign mst[g].gnt     = tgt_gnt[g];
      assign mst[g].r_valid = tgt_rvalid[g];
      assign mst[g].r_data  = tgt_rdata[g];
      assign mst[g].r_opc   = tgt_ropc[g];
      assign mst[g].r_user  = tgt_ruser[g];
      assign mreq[g]        = mst[g].req;
      assign madd[g]        = mst[g].add;
   end

   hci_core_memmap_demux #(
      .NB_REGION       (NB_REGION),
      .NB_TARGET       (NB_TARGET),
      .MAX_OUTSTANDING (MAX_OUT),
      .AW              (AW),
      .DW              (DW),
      .UW              (UW),
      .ERR_DATA        (32'hbadacce5)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .clear_i         (clear),
      .region_start_i  (region_start),
      .region_end_i    (region_end),
      .region_target_i (region_target),
      .slave           (slv),
      .master          (mst),
      .err_o           (err),
      .err_addr_o      (err_addr)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [AW-1:0] r_lo  [NB_REGION];
   logic [AW-1:0] r_hi  [NB_REGION];
   int            r_tgt [NB_REGION];
   int            exp_q [$];
   bit            m_err;
   logic [AW-1:0] m_err_addr;

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_region(input int idx, input logic [AW-1:0] lo, input logic [AW-1:0] hi, input int tgt);
      r_lo[idx]  = lo;
      r_hi[idx]  = hi;
      r_tgt[idx] = tgt;
      region_start[idx*AW +: AW] = lo;
      region_end[idx*AW +: AW]   = hi;
      region_target[idx]         = (tgt != 0);
   endtask

   function automatic int decode(input logic [AW-1:0] a);
      for (int i = 0; i < int'(NB_REGION); i++)
         if (r_lo[i] < r_hi[i] && a >= r_lo[i] && a < r_hi[i]) return r_tgt[i];
      return ERR_TGT;
   endfunction

   task automatic apply_stimulus();
      slv.req  = ($urandom_range(0, 3) != 0);
      slv.add  = AW'($urandom_range(0, 32'h3fff));
      slv.wen  = 1'($urandom_range(0, 1));
      slv.data = $urandom;
      tgt_gnt  = NB_TARGET'($urandom_range(0, 3));
      tgt_ropc = NB_TARGET'($urandom_range(0, 3));
      for (int k = 0; k < int'(NB_TARGET); k++) begin
         tgt_rdata[k] = $urandom;
         tgt_ruser[k] = UW'($urandom_range(0, 3));
      end
      tgt_rvalid = '0;
      if (exp_q.size() > 0 && exp_q[0] != ERR_TGT && $urandom_range(0, 1) == 1)
         tgt_rvalid[exp_q[0]] = 1'b1;
   endtask

   initial begin
      int            t;
      int            n;
      int            h;
      bit            ok;
      logic          e_gnt;
      logic          e_rv;
      logic          e_opc;
      logic [NB_TARGET-1:0] e_mreq;
      logic [DW-1:0] e_rd;
      logic [UW-1:0] e_user;

      rst = 1'b1;
      clear = 1'b0;
      region_start = '0;
      region_end = '0;
      region_target = '0;
      for (int i = 0; i < int'(NB_REGION); i++) set_region(i, '0, '0, 0);
      slv.req = 1'b0; slv.add = '0; slv.wen = 1'b1; slv.data = '0; slv.be = '1; slv.user = '0;
      tgt_gnt = '0; tgt_rvalid = '0; tgt_ropc = '0;
      for (int k = 0; k < int'(NB_TARGET); k++) begin
         tgt_rdata[k] = '0;
         tgt_ruser[k] = '0;
      end
      repeat (2) tick();
      rst = 1'b0;
      #1;
      check_output("rst_err", err, 0);
      check_output("rst_err_addr", err_addr, 0);
      check_output("rst_rvalid", slv.r_valid, 0);
      check_output("rst_rdata", slv.r_data, 0);

      // Basic read to T0, then an immediate read to T1 proves the count drained
      set_region(0, 32'h0, 32'h1000, 0);
      set_region(1, 32'h1000, 32'h2000, 1);
      slv.req = 1'b1; slv.add = 32'h0800; tgt_gnt = 2'b01;
      #1;
      check_output("t1_mreq", mreq, 2'b01);
      check_output("t1_gnt", slv.gnt, 1);
      check_output("t1_fwd_add", madd[0], 32'h0800);
      tick();
      slv.req = 1'b0; tgt_gnt = '0; tgt_rvalid = 2'b01; tgt_rdata[0] = 32'hCAFE;
      #1;
      check_output("t1_rvalid", slv.r_valid, 1);
      check_output("t1_rdata", slv.r_data, 32'hCAFE);
      tick();
      tgt_rvalid = '0; slv.req = 1'b1; slv.add = 32'h1800; tgt_gnt = 2'b10;
      #1;
      check_output("t1_idle_rvalid", slv.r_valid, 0);
      check_output("t1_switch_gnt", slv.gnt, 1);
      check_output("t1_switch_mreq", mreq, 2'b10);
      tick();
      slv.req = 1'b0; tgt_gnt = '0; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h1234;
      #1;
      check_output("t1_t1_rdata", slv.r_data, 32'h1234);
      tick();
      tgt_rvalid = '0;

      // Overlapping regions: lowest index wins
      set_region(0, 32'h0, 32'h2000, 1);
      set_region(1, 32'h1000, 32'h3000, 0);
      slv.req = 1'b1; slv.add = 32'h1800; tgt_gnt = 2'b11;
      #1;
      check_output("t2_mreq", mreq, 2'b10);
      check_output("t2_gnt", slv.gnt, 1);
      tick();
      slv.req = 1'b0; tgt_gnt = '0; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h5678;
      #1;
      check_output("t2_rdata", slv.r_data, 32'h5678);
      tick();
      tgt_rvalid = '0;

      // Fill to MAX_OUT on T0, then a T1 request stalls until T0 drains
      set_region(0, 32'h0, 32'h1000, 0);
      set_region(1, 32'h1000, 32'h2000, 1);
      slv.req = 1'b1; tgt_gnt = 2'b01;
      for (int i = 0; i < int'(MAX_OUT); i++) begin
         slv.add = AW'(i * 4);
         #1;
         check_output("t3_fill_gnt", slv.gnt, 1);
         tick();
      end
      slv.add = 32'h10;
      #1;
      check_output("t3_full_gnt", slv.gnt, 0);
      check_output("t3_full_mreq", mreq, 2'b00);
      slv.add = 32'h1000; tgt_gnt = 2'b11;
      #1;
      check_output("t3_stall_gnt", slv.gnt, 0);
      check_output("t3_stall_mreq", mreq, 2'b00);
      tick();
      for (int r = 0; r < int'(MAX_OUT); r++) begin
         tgt_rvalid = 2'b01; tgt_rdata[0] = DW'(32'hA0 + r);
         #1;
         check_output("t3_drain_rdata", slv.r_data, DW'(32'hA0 + r));
         check_output("t3_drain_gnt", slv.gnt, 0);
         tick();
      end
      tgt_rvalid = '0;
      #1;
      check_output("t3_t1_gnt", slv.gnt, 1);
      check_output("t3_t1_mreq", mreq, 2'b10);
      tick();
      slv.req = 1'b0; tgt_gnt = '0; tgt_rvalid = 2'b10;
      #1;
      check_output("t3_t1_rvalid", slv.r_valid, 1);
      tick();
      tgt_rvalid = '0;

      // Unmapped accesses: error response and sticky first address
      tgt_ruser[0] = 2'b11; tgt_ruser[1] = 2'b11;
      slv.req = 1'b1; slv.add = 32'h8000;
      #1;
      check_output("t4_gnt", slv.gnt, 1);
      check_output("t4_mreq", mreq, 2'b00);
      check_output("t4_err_before", err, 0);
      tick();
      slv.req = 1'b0;
      #1;
      check_output("t4_rvalid", slv.r_valid, 1);
      check_output("t4_rdata", slv.r_data, ERR_WORD);
      check_output("t4_ropc", slv.r_opc, 1);
      check_output("t4_ruser", slv.r_user, 0);
      check_output("t4_err", err, 1);
      check_output("t4_err_addr", err_addr, 32'h8000);
      tick();
      slv.req = 1'b1; slv.add = 32'h9000;
      #1;
      check_output("t4_gnt2", slv.gnt, 1);
      tick();
      slv.req = 1'b0;
      #1;
      check_output("t4_rvalid2", slv.r_valid, 1);
      check_output("t4_err_addr_kept", err_addr, 32'h8000);
      tick();
      check_output("t4_single_rsp", slv.r_valid, 0);
      tgt_ruser[0] = '0; tgt_ruser[1] = '0;

      // Simultaneous accept and response, then full with same-cycle response
      slv.req = 1'b1; slv.add = 32'h100; tgt_gnt = 2'b01;
      repeat (2) tick();
      slv.add = 32'h104; tgt_rvalid = 2'b01;
      #1;
      check_output("t5_same_gnt", slv.gnt, 1);
      check_output("t5_same_rvalid", slv.r_valid, 1);
      tick();
      tgt_rvalid = '0;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_output("t5_refill_gnt", slv.gnt, 1);
         tick();
      end
      tgt_rvalid = 2'b01;
      #1;
      check_output("t5_full_rsp_gnt", slv.gnt, 0);
      tick();
      tgt_rvalid = '0;
      #1;
      check_output("t5_freed_gnt", slv.gnt, 1);
      tick();
      slv.req = 1'b0; tgt_rvalid = 2'b01;
      tick();

      // Soft clear with 3 outstanding on T0
      tgt_rvalid = '0; tgt_rdata[0] = 32'hDEAD; clear = 1'b1;
      tick();
      clear = 1'b0;
      #1;
      check_output("t6_err", err, 0);
      check_output("t6_err_addr", err_addr, 0);
      check_output("t6_rvalid", slv.r_valid, 0);
      check_output("t6_rdata", slv.r_data, 0);
      slv.req = 1'b1; slv.add = 32'h1000; tgt_gnt = 2'b10;
      #1;
      check_output("t6_gnt", slv.gnt, 1);
      check_output("t6_mreq", mreq, 2'b10);
      tick();
      slv.req = 1'b0; tgt_gnt = '0; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h77;
      #1;
      check_output("t6_rdata_t1", slv.r_data, 32'h77);
      tick();
      tgt_rvalid = '0;

      // Randomized traffic against the reference model
      m_err = 1'b0;
      m_err_addr = '0;
      exp_q.delete();
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < int'(NB_REGION); i++)
            set_region(i, AW'($urandom_range(0, 32'h30) << 8), AW'($urandom_range(0, 32'h30) << 8),
                       int'($urandom_range(0, NB_TARGET - 1)));
         for (int c = 0; c < 150; c++) begin
            apply_stimulus();
            #1;
            t = decode(slv.add);
            n = exp_q.size();
            ok = (n < int'(MAX_OUT)) && (n == 0 || exp_q[0] == t);
            e_gnt = ok && ((t == ERR_TGT) ? slv.req : tgt_gnt[t]);
            e_mreq = '0;
            if (slv.req && ok && t != ERR_TGT) e_mreq[t] = 1'b1;
            e_rv = 1'b0; e_rd = '0; e_opc = 1'b0; e_user = '0;
            if (n > 0) begin
               h = exp_q[0];
               if (h == ERR_TGT) begin
                  e_rv = 1'b1; e_rd = ERR_WORD; e_opc = 1'b1;
               end else begin
                  e_rv = tgt_rvalid[h]; e_rd = tgt_rdata[h]; e_opc = tgt_ropc[h]; e_user = tgt_ruser[h];
               end
            end
            check_output("rnd_gnt", slv.gnt, e_gnt);
            check_output("rnd_mreq", mreq, e_mreq);
            check_output("rnd_rvalid", slv.r_valid, e_rv);
            check_output("rnd_rdata", slv.r_data, e_rd);
            check_output("rnd_ropc", slv.r_opc, e_opc);
            check_output("rnd_ruser", slv.r_user, e_user);
            check_output("rnd_err", err, m_err);
            check_output("rnd_err_addr", err_addr, m_err_addr);
            if (e_rv) void'(exp_q.pop_front());
            if (slv.req && e_gnt) begin
               exp_q.push_back(t);
               if (t == ERR_TGT && !m_err) begin
                  m_err = 1'b1;
                  m_err_addr = slv.add;
               end
            end
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
